regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Controls the shared register file write port and tracks pending destination registers (scoreboard).
- Stalls issue on RAW/WAW hazards against in-flight writes.
- Arbitrates the ALU and memory writeback requesters onto the single write port, round-robin, through a registered output stage.
- Sits between decode/issue, the execution units, and the register file write port (write_enable, rd_offset, rd_data_in).

Parameters:
- REG_WIDTH, 5, register index width; REG_COUNT = 1 << REG_WIDTH.
- WIDTH, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous; clears all pending (busy) state.
- issue_valid  in  1  decode presents an instruction.
- issue_rd  in  REG_WIDTH  destination register; 0 = no write.
- issue_rs1  in  REG_WIDTH  source register 1.
- issue_rs2  in  REG_WIDTH  source register 2.
- issue_ready  out  1  instruction accepted this cycle (no hazard).
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  REG_WIDTH  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  memory writeback request.
- mem_rd  in  REG_WIDTH  memory destination register.
- mem_data  in  WIDTH  load data.
- mem_ready  out  1  memory request granted this cycle.
- rf_write_enable  out  1  register file write enable.
- rf_rd_offset  out  REG_WIDTH  register file write index.
- rf_rd_data  out  WIDTH  register file write data.
- busy_mask  out  REG_COUNT  pending-write bit per register; bit 0 always 0.
- wb_error  out  1  sticky: writeback arrived for a register that was not busy.

Behaviour:
- Reset (rst low, async):
  - busy_mask = 0, rf_write_enable = 0, rf_rd_offset = 0, rf_rd_data = 0, wb_error = 0.
  - last_grant = MEM, so the ALU wins the first tie.
- Hazard check (combinational, uses registered busy_mask only, no bypass):
  - hazard = busy[rs1] | busy[rs2] | busy[rd].
  - issue_ready = issue_valid & ~hazard & ~flush.
  - busy[0] is never set, so x0 never causes a hazard.
- Issue accept (issue_ready = 1): busy[issue_rd] set at the next edge if issue_rd != 0.
- Arbitration (combinational grant, valid/ready handshake):
  - Only alu_valid: ALU granted.
  - Only mem_valid: MEM granted.
  - Both valid: grant the requester not named by last_grant.
  - last_grant updates to the granted requester at the edge.
  - flush = 1 forces alu_ready = mem_ready = 0.
  - A requester holds valid, rd and data stable until its ready is seen.
- Writeback stage: 1-cycle latency from grant to port.
  - Edge after a grant: rf_rd_offset and rf_rd_data load the granted rd/data.
  - rf_write_enable = 1 only if the granted rd != 0.
  - A write with rd = 0 is consumed (ready = 1) but never drives a write.
  - No grant: rf_write_enable = 0 next cycle; offset and data hold their last value.
- Busy clear: on a grant, busy[granted rd] clears at the same edge the write is registered.
  - Issue that depends on that register stalls in the grant cycle.
  - It is accepted the following cycle, when the register file write lands.
  - This relies on the register file's write-before-read timing.
- Error: granted rd != 0 with busy[rd] = 0 sets wb_error, held until reset. The write still proceeds.
- Simultaneous events:
  - Set and clear of the same index in one cycle cannot occur: issue is blocked while rd is busy.
  - Set and clear of different indices both apply.
  - flush beats set: an issue in a flush cycle is not accepted and busy_mask = 0 next cycle.
- Reset mid-operation: all state returns to reset values immediately; the in-flight registered write is dropped (rf_write_enable = 0).

Test Plan:
- Reset, then issue rd=5, rs1=1, rs2=2 -> issue_ready=1; busy_mask=0x20 next cycle; issue rs1=5 stalls (issue_ready=0).
- With busy[5] set, alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1 that cycle; next cycle rf_write_enable=1, rf_rd_offset=5, rf_rd_data=0xDEADBEEF, busy_mask=0; the stalled rs1=5 issue is accepted that cycle.
- alu and mem valid together for 3 cycles (rd=3, rd=4, re-presented after each grant) -> grants ALU, MEM, ALU; rf_rd_offset sequence 3, 4, 3.
- mem_valid rd=0 data=0x1234 -> mem_ready=1; rf_write_enable stays 0 next cycle; wb_error stays 0.
- busy[7] and busy[9] set, flush=1 with issue_valid rd=8 -> issue_ready=0, alu_ready=0; busy_mask=0 next cycle; alu_valid rd=7 afterwards sets wb_error=1 and still writes r7.
- rst low during a granted write (rd=6) -> rf_write_enable=0 and busy_mask=0 immediately; after release, the ALU wins the first tie.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Register file write-port scheduler: tracks pending destination registers,
// stalls issue on hazards, and arbitrates ALU/memory writebacks round-robin.
module regfile_wb_scheduler #(
    parameter int REG_WIDTH = 5,
    parameter int WIDTH     = 32,
    localparam int REG_COUNT = 1 << REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [REG_WIDTH-1:0] issue_rd,
    input  logic [REG_WIDTH-1:0] issue_rs1,
    input  logic [REG_WIDTH-1:0] issue_rs2,
    output logic                 issue_ready,
    input  logic                 alu_valid,
    input  logic [REG_WIDTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]     alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_WIDTH-1:0] mem_rd,
    input  logic [WIDTH-1:0]     mem_data,
    output logic                 mem_ready,
    output logic                 rf_write_enable,
    output logic [REG_WIDTH-1:0] rf_rd_offset,
    output logic [WIDTH-1:0]     rf_rd_data,
    output logic [REG_COUNT-1:0] busy_mask,
    output logic                 wb_error
);

    logic                 last_grant_mem;
    logic                 hazard;
    logic                 grant_alu;
    logic                 grant_mem;
    logic                 grant_any;
    logic [REG_WIDTH-1:0] wb_rd;
    logic [WIDTH-1:0]     wb_data;
    logic [REG_COUNT-1:0] busy_next;

    // Hazard check sees only the registered mask; the write port lands one
    // cycle after the grant, so dependants must wait for that cycle.
    assign hazard      = busy_mask[issue_rs1] | busy_mask[issue_rs2] | busy_mask[issue_rd];
    assign issue_ready = issue_valid & ~hazard & ~flush;

    assign grant_alu = ~flush & alu_valid & (~mem_valid | last_grant_mem);
    assign grant_mem = ~flush & mem_valid & (~alu_valid | ~last_grant_mem);
    assign grant_any = grant_alu | grant_mem;
    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    assign wb_rd   = grant_mem ? mem_rd   : alu_rd;
    assign wb_data = grant_mem ? mem_data : alu_data;

    always_comb begin
        busy_next = busy_mask;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (grant_any)
                busy_next[wb_rd] = 1'b0;
            if (issue_ready && (issue_rd != '0))
                busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_mask       <= '0;
            rf_write_enable <= 1'b0;
            rf_rd_offset    <= '0;
            rf_rd_data      <= '0;
            wb_error        <= 1'b0;
            last_grant_mem  <= 1'b1;
        end else begin
            busy_mask       <= busy_next;
            rf_write_enable <= grant_any && (wb_rd != '0);
            if (grant_any) begin
                rf_rd_offset   <= wb_rd;
                rf_rd_data     <= wb_data;
                last_grant_mem <= grant_mem;
            end
            // Writeback to a register nobody was waiting on: flag it, still write.
            if (grant_any && (wb_rd != '0) && !busy_mask[wb_rd])
                wb_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: write-port transactions checked through a scoreboard queue,
// handshake and busy state checked against hand-computed values.
module tb_regfile_wb_scheduler;

    localparam int RW = 5;
    localparam int W  = 32;
    localparam int RC = 1 << RW;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          issue_valid;
    logic [RW-1:0] issue_rd, issue_rs1, issue_rs2;
    logic          issue_ready;
    logic          alu_valid;
    logic [RW-1:0] alu_rd;
    logic [W-1:0]  alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [RW-1:0] mem_rd;
    logic [W-1:0]  mem_data;
    logic          mem_ready;
    logic          rf_write_enable;
    logic [RW-1:0] rf_rd_offset;
    logic [W-1:0]  rf_rd_data;
    logic [RC-1:0] busy_mask;
    logic          wb_error;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [W-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors;
    int  miscompares;

    regfile_wb_scheduler #(.REG_WIDTH(RW), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_write_enable(rf_write_enable), .rf_rd_offset(rf_rd_offset),
        .rf_rd_data(rf_rd_data), .busy_mask(busy_mask), .wb_error(wb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [RW-1:0] rd, input logic [W-1:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
    endtask

    // Monitor: every write the port presents must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && rf_write_enable) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                         rf_rd_offset, rf_rd_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_rd_offset", 64'(rf_rd_offset), 64'(e.rd));
                chk("wb_rd_data", 64'(rf_rd_data), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy_mask", 64'(busy_mask), 64'h0);
        chk("rst_we", 64'(rf_write_enable), 64'h0);
        chk("rst_offset", 64'(rf_rd_offset), 64'h0);
        chk("rst_data", 64'(rf_rd_data), 64'h0);
        chk("rst_wb_error", 64'(wb_error), 64'h0);
        rst = 1'b1;

        // Basic issue, then RAW stall on r5.
        @(negedge clk);
        issue(5, 1, 2);
        #1 chk("issue_r5_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        chk("busy_after_r5", 64'(busy_mask), 64'h20);
        issue(10, 5, 0);
        #1 chk("raw_stall_ready", 64'(issue_ready), 64'h0);

        // ALU clears r5; stalled issue is accepted the following cycle.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 chk("alu_r5_ready", 64'(alu_ready), 64'h1);
        chk("grant_cycle_stall", 64'(issue_ready), 64'h0);
        push(5, 32'hDEADBEEF);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("busy_after_clear5", 64'(busy_mask), 64'h0);
        chk("we_r5", 64'(rf_write_enable), 64'h1);
        #1 chk("stalled_issue_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        issue_valid = 1'b0;
        chk("busy_r10", 64'(busy_mask), 64'h400);

        // Memory-only write clears r10 and leaves last_grant = MEM.
        mem_valid = 1'b1; mem_rd = 10; mem_data = 32'h0A0A0A0A;
        #1 chk("mem_r10_ready", 64'(mem_ready), 64'h1);
        push(10, 32'h0A0A0A0A);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("busy_after_r10", 64'(busy_mask), 64'h0);

        // Round-robin under contention: ALU, MEM, ALU.
        issue(3, 0, 0);
        #1 chk("issue_r3_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        chk("busy_r3", 64'(busy_mask), 64'h08);
        issue(4, 0, 0);
        #1 chk("issue_r4_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        issue_valid = 1'b0;
        chk("busy_r3_r4", 64'(busy_mask), 64'h18);
        alu_valid = 1'b1; alu_rd = 3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 4; mem_data = 32'h44;
        #1 chk("tie1_alu_ready", 64'(alu_ready), 64'h1);
        chk("tie1_mem_ready", 64'(mem_ready), 64'h0);
        push(3, 32'h33);
        @(negedge clk);
        chk("busy_tie1", 64'(busy_mask), 64'h10);
        alu_data = 32'h333;
        issue(3, 0, 0);
        #1 chk("tie2_alu_ready", 64'(alu_ready), 64'h0);
        chk("tie2_mem_ready", 64'(mem_ready), 64'h1);
        chk("reissue_r3_ready", 64'(issue_ready), 64'h1);
        push(4, 32'h44);
        @(negedge clk);
        issue_valid = 1'b0;
        mem_valid = 1'b0;
        chk("busy_tie2", 64'(busy_mask), 64'h08);
        #1 chk("tie3_alu_ready", 64'(alu_ready), 64'h1);
        push(3, 32'h333);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("busy_tie3", 64'(busy_mask), 64'h0);

        // Write to x0 is consumed without a port write.
        mem_valid = 1'b1; mem_rd = 0; mem_data = 32'h1234;
        #1 chk("mem_x0_ready", 64'(mem_ready), 64'h1);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("x0_no_write", 64'(rf_write_enable), 64'h0);
        chk("x0_no_error", 64'(wb_error), 64'h0);

        // Flush beats issue and grant; late writeback to r7 flags an error.
        issue(7, 0, 0);
        @(negedge clk);
        issue(9, 0, 0);
        @(negedge clk);
        chk("busy_r7_r9", 64'(busy_mask), 64'h280);
        flush = 1'b1;
        issue(8, 0, 0);
        alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h77;
        #1 chk("flush_issue_ready", 64'(issue_ready), 64'h0);
        chk("flush_alu_ready", 64'(alu_ready), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        issue_valid = 1'b0;
        chk("busy_after_flush", 64'(busy_mask), 64'h0);
        #1 chk("post_flush_alu_ready", 64'(alu_ready), 64'h1);
        push(7, 32'h77);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("wb_error_set", 64'(wb_error), 64'h1);

        // Reset lands while the r6 write is sitting in the output stage.
        issue(6, 0, 0);
        @(negedge clk);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 6; alu_data = 32'h66;
        #1 chk("alu_r6_ready", 64'(alu_ready), 64'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_mid_we", 64'(rf_write_enable), 64'h0);
        chk("rst_mid_busy", 64'(busy_mask), 64'h0);
        chk("rst_mid_error", 64'(wb_error), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 11; alu_data = 32'hB0B;
        mem_valid = 1'b1; mem_rd = 12; mem_data = 32'hC0C;
        #1 chk("post_rst_alu_ready", 64'(alu_ready), 64'h1);
        chk("post_rst_mem_ready", 64'(mem_ready), 64'h0);
        push(11, 32'hB0B);
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("post_rst_error", 64'(wb_error), 64'h1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
